// File: rtl/gpio_bus_arbiter_if.sv
// Requester-side bus of the GPIO arbiter.
// All requesters share one packed bundle; requester k owns bit k of req/we/ack and the
// k-th ADDR_W / DATA_W slice of addr/wdata.
//   master modport : requesters drive req/we/addr/wdata and observe ack/err/rdata
//   slave modport  : the arbiter observes the requests and drives ack/err/rdata
interface gpio_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  err,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output err,
    output rdata
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the GPIO register bus between NUM_REQ masters.
// One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP when the
// block select addr[7:5] does not decode to one of the five GPIO blocks.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         requester bundle: req/we/addr/wdata in, ack/err/rdata out
//   busy_o              high whenever the FSM is not idle
//   gpio*_sel_o         one-hot block selects (A, B, C, switches, LEDs), ACCESS only
//   peri_we_o           write strobe, ACCESS only
//   peri_addr_o         register offset addr[4:0], ACCESS only
//   peri_wdata_o        write data, ACCESS only
//   peri_rdata_i        read data from gpio_top, valid the cycle after the select
module gpio_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_bus_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              gpioA_sel_o,
  output logic              gpioB_sel_o,
  output logic              gpioC_sel_o,
  output logic              gpsw_sel_o,
  output logic              gpled_sel_o,
  output logic              peri_we_o,
  output logic [4:0]        peri_addr_o,
  output logic [DATA_W-1:0] peri_wdata_o,
  input  logic [DATA_W-1:0] peri_rdata_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [IdxW:0]        NumReqW = (IdxW + 1)'(NUM_REQ);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   OneReq  = {{(NUM_REQ - 1){1'b0}}, 1'b1};
  localparam logic [4:0]           OneSel  = 5'b00001;
  localparam logic [2:0]           LastBlk = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_q;
  logic [IdxW-1:0]     win_q;
  logic                we_q;
  logic                err_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [4:0]          sel_q;
  logic                peri_we_q;
  logic [4:0]          peri_addr_q;
  logic [DATA_W-1:0]   peri_wdata_q;

  // Per-requester views of the packed request fields.
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first set req bit at rr_q, rr_q+1, ... wrapping at NUM_REQ.
  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IdxW + 1)'(i);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!win_found && bus.req[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [2:0]        win_blk;
  logic [IdxW-1:0]   rr_next;

  always_comb begin
    win_we    = bus.we[win_idx];
    win_addr  = addr_arr[win_idx];
    win_wdata = wdata_arr[win_idx];
    win_blk   = win_addr[7:5];
    rr_next   = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
  end

  // Single-process FSM; every bus-facing output except rdata is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      win_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      ack_q        <= '0;
      sel_q        <= '0;
      peri_we_q    <= 1'b0;
      peri_addr_q  <= '0;
      peri_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            win_q <= win_idx;
            we_q  <= win_we;
            rr_q  <= rr_next;
            if (win_blk <= LastBlk) begin
              state_q      <= StAccess;
              err_q        <= 1'b0;
              sel_q        <= OneSel << win_blk;
              peri_we_q    <= win_we;
              peri_addr_q  <= win_addr[4:0];
              peri_wdata_q <= win_wdata;
            end else begin
              // Undecoded block: no peripheral access, answer straight away.
              state_q <= StResp;
              err_q   <= 1'b1;
              ack_q   <= OneReq << win_idx;
            end
          end
        end
        StAccess: begin
          state_q      <= StResp;
          ack_q        <= OneReq << win_q;
          sel_q        <= '0;
          peri_we_q    <= 1'b0;
          peri_addr_q  <= '0;
          peri_wdata_q <= '0;
        end
        StResp: begin
          state_q <= StIdle;
          ack_q   <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Read data arrives from gpio_top during RESP, so it is forwarded rather than registered.
  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (state_q == StResp && !we_q && !err_q) begin
      rdata = peri_rdata_i;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata;

  assign busy_o       = (state_q != StIdle);
  assign gpioA_sel_o  = sel_q[0];
  assign gpioB_sel_o  = sel_q[1];
  assign gpioC_sel_o  = sel_q[2];
  assign gpsw_sel_o   = sel_q[3];
  assign gpled_sel_o  = sel_q[4];
  assign peri_we_o    = peri_we_q;
  assign peri_addr_o  = peri_addr_q;
  assign peri_wdata_o = peri_wdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter with three requesters. A transaction-level reference model
// (grant cycle, select cycle, ack cycle, pointer, register contents) predicts every output
// each cycle; a small peripheral model stands in for gpio_top.
module tb_gpio_bus_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          busy;
  logic          sel_a, sel_b, sel_c, sel_sw, sel_led;
  logic          peri_we;
  logic [4:0]    peri_addr;
  logic [31:0]   peri_wdata;
  logic [31:0]   peri_rdata;

  gpio_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy_o       (busy),
    .gpioA_sel_o  (sel_a),
    .gpioB_sel_o  (sel_b),
    .gpioC_sel_o  (sel_c),
    .gpsw_sel_o   (sel_sw),
    .gpled_sel_o  (sel_led),
    .peri_we_o    (peri_we),
    .peri_addr_o  (peri_addr),
    .peri_wdata_o (peri_wdata),
    .peri_rdata_i (peri_rdata)
  );

  // Requester drive.
  logic [NR-1:0] m_req;
  logic [NR-1:0] m_we;
  logic [7:0]    m_addr  [NR];
  logic [31:0]   m_wdata [NR];

  always_comb begin
    bus.req   = m_req;
    bus.we    = m_we;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int k = 0; k < NR; k++) begin
      bus.addr[k*AW +: AW]  = m_addr[k];
      bus.wdata[k*DW +: DW] = m_wdata[k];
    end
  end

  function automatic logic [31:0] init_val(int b, int o);
    logic [31:0] v;
    v = 32'(b * 32 + o + 1) * 32'h9E37_79B9;
    if (b == 0 && o == 4) v = 32'hA5A5_0F0F;
    return v;
  endfunction

  // Peripheral stand-in: registers per block, read data returned the cycle after select.
  logic [4:0]  sel_vec;
  logic [31:0] pmem [5][32];
  logic        load;
  assign sel_vec = {sel_led, sel_sw, sel_c, sel_b, sel_a};

  always @(posedge clk) begin
    if (load) begin
      for (int b = 0; b < 5; b++)
        for (int o = 0; o < 32; o++) pmem[b][o] <= init_val(b, o);
      peri_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        if (sel_vec[b]) begin
          if (peri_we) pmem[b][peri_addr] <= peri_wdata;
          else         peri_rdata <= pmem[b][peri_addr];
        end
      end
    end
  end

  // Reference model state.
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          next_free = 0;
  int          g_cyc = -10;
  int          sel_cyc = -10;
  int          ack_cyc = -10;
  int          rr = 0;
  int          win = 0;
  logic        t_we = 1'b0;
  logic        t_err = 1'b0;
  logic [7:0]  t_addr = 8'h0;
  logic [31:0] t_wdata = 32'h0;
  logic [31:0] rmem [5][32];
  logic [NR-1:0] hold_mask = '0;
  int          acked = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_and_check();
    logic [4:0]    e_sel;
    logic [NR-1:0] e_ack;
    logic [31:0]   e_rdata;
    logic [2:0]    blk;
    logic [4:0]    off;
    acked = -1;
    if (rst_n && cyc >= next_free && m_req != '0) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (rr + i) % NR;
        if (m_req[k]) begin
          win = k;
          break;
        end
      end
      t_we    = m_we[win];
      t_addr  = m_addr[win];
      t_wdata = m_wdata[win];
      t_err   = (t_addr[7:5] > 3'd4);
      g_cyc   = cyc;
      sel_cyc = t_err ? -10 : cyc + 1;
      ack_cyc = t_err ? cyc + 1 : cyc + 2;
      next_free = ack_cyc + 1;
      rr = (win + 1) % NR;
    end
    blk = t_addr[7:5];
    off = t_addr[4:0];
    e_sel = '0;
    if (cyc == sel_cyc) e_sel[blk] = 1'b1;
    e_ack = '0;
    if (cyc == ack_cyc) begin
      e_ack[win] = 1'b1;
      acked = win;
    end
    e_rdata = (cyc == ack_cyc && !t_we && !t_err) ? rmem[blk][off] : 32'h0;
    chk("sel", 32'(sel_vec), 32'(e_sel));
    chk("peri_we", 32'(peri_we), (cyc == sel_cyc) ? 32'(t_we) : 32'h0);
    chk("peri_addr", 32'(peri_addr), (cyc == sel_cyc) ? 32'(off) : 32'h0);
    chk("peri_wdata", peri_wdata, (cyc == sel_cyc) ? t_wdata : 32'h0);
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("err", 32'(bus.err), 32'(cyc == ack_cyc && t_err));
    chk("rdata", bus.rdata, e_rdata);
    chk("busy", 32'(busy), 32'(cyc > g_cyc && cyc <= ack_cyc));
    if (cyc == sel_cyc && t_we) rmem[blk][off] = t_wdata;
  endtask

  // One clock: check mid-cycle, then let the acked requester drop its request.
  task automatic cycle();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
    cyc++;
    if (acked >= 0 && !hold_mask[acked]) m_req[acked] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (m_req == '0 && cyc > ack_cyc) break;
      cycle();
    end
    chk("drain_done", 32'(m_req == '0 && cyc > ack_cyc), 32'h1);
  endtask

  task automatic set_req(input int k, input logic we, input logic [7:0] a,
                         input logic [31:0] d);
    m_we[k]    = we;
    m_addr[k]  = a;
    m_wdata[k] = d;
    m_req[k]   = 1'b1;
  endtask

  initial begin
    m_req = '0;
    m_we  = '0;
    for (int k = 0; k < NR; k++) begin
      m_addr[k]  = 8'h0;
      m_wdata[k] = 32'h0;
    end
    for (int b = 0; b < 5; b++)
      for (int o = 0; o < 32; o++) rmem[b][o] = init_val(b, o);
    load = 1'b1;

    // Reset state.
    cycle();
    load = 1'b0;
    cycle();
    rst_n = 1'b1;

    // Single read from port A, offset 4.
    set_req(0, 1'b0, 8'h04, 32'h0);
    drain();
    // Write to LEDs.
    set_req(0, 1'b1, 8'h80, 32'h0000_BEEF);
    drain();
    // Read back the LED register just written.
    set_req(0, 1'b0, 8'h80, 32'h0);
    drain();

    // Contention: two masters held continuously.
    hold_mask = 3'b011;
    set_req(0, 1'b0, 8'h44, 32'h0);
    set_req(1, 1'b1, 8'h65, 32'h1234_5678);
    repeat (12) cycle();
    hold_mask = '0;
    drain();

    // Decode error.
    set_req(0, 1'b0, 8'hE0, 32'h0);
    drain();

    // Reset while port B is selected.
    set_req(1, 1'b0, 8'h21, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (cyc == sel_cyc) break;
      cycle();
    end
    chk("pre_reset_selB", 32'(sel_b), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel_vec), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we", 32'(peri_we), 32'h0);
    chk("rst_addr", 32'(peri_addr), 32'h0);
    chk("rst_wdata", peri_wdata, 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    m_req = '0;
    rr = 0;
    next_free = 0;
    g_cyc = -10;
    sel_cyc = -10;
    ack_cyc = -10;
    cycle();
    cycle();
    rst_n = 1'b1;
    // Pointer back at 0: requesters 1 and 2 pending, 1 must win first.
    set_req(1, 1'b0, 8'h60, 32'h0);
    set_req(2, 1'b1, 8'h41, 32'hCAFE_0001);
    cycle();
    chk("post_reset_winner", 32'(win), 32'h1);
    drain();

    // Wrap: 100 then 011.
    set_req(2, 1'b0, 8'h41, 32'h0);
    drain();
    set_req(0, 1'b1, 8'h10, 32'h0BAD_F00D);
    set_req(1, 1'b0, 8'h10, 32'h0);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (!m_req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(k, 1'($urandom_range(0, 1)),
                    {3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))}, $urandom);
          end
        end else if (!(win == k && cyc <= ack_cyc) && $urandom_range(0, 15) == 0) begin
          m_req[k] = 1'b0;
        end
      end
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
